// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry skid buffer.
// Define IMM_GEN_RVC_EN to add decode of the supported compressed (RVC) encodings.
module imm_gen_pipe #(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 8,
    parameter bit AUIPC_PRESHIFT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_unk,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             unk;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] w_imm32;
    logic [2:0]  w_fmt;
    logic        w_unk;
    logic        w_push;
    logic        w_pop;
    entry_t      w_new;
    entry_t      r_main;
    entry_t      r_skid;
    logic        r_main_v;
    logic        r_skid_v;

    always_comb begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_fmt   = FMT_I;
        w_unk   = 1'b0;
        unique case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_fmt = FMT_I;
            end
            7'b0100011: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_fmt   = FMT_S;
            end
            7'b1100011: begin
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
                w_fmt   = FMT_B;
            end
            7'b0110111: begin
                w_imm32 = {in_inst[31:12], 12'b0};
                w_fmt   = FMT_U;
            end
            7'b0010111: begin
                w_imm32 = AUIPC_PRESHIFT ? {in_inst[31], in_inst[31:12], 11'b0}
                                         : {in_inst[31:12], 12'b0};
                w_fmt   = FMT_U;
            end
            7'b1101111: begin
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
                w_fmt   = FMT_J;
            end
            7'b0110011: begin
                w_imm32 = '0;
                w_fmt   = FMT_R;
            end
            default: begin
                w_unk = 1'b1;
            end
        endcase
`ifdef IMM_GEN_RVC_EN
        // Compressed words override the 32-bit decode; only quadrant 01 is supported.
        if (in_inst[1:0] != 2'b11) begin
            w_imm32 = '0;
            w_fmt   = FMT_R;
            w_unk   = 1'b1;
            if (in_inst[1:0] == 2'b01) begin
                unique case (in_inst[15:13])
                    3'b000, 3'b010: begin
                        w_imm32 = {{26{in_inst[12]}}, in_inst[12], in_inst[6:2]};
                        w_fmt   = FMT_I;
                        w_unk   = 1'b0;
                    end
                    3'b011: begin
                        if (in_inst[11:7] != 5'd2) begin
                            w_imm32 = {{14{in_inst[12]}}, in_inst[12],
                                       in_inst[6:2], 12'b0};
                            w_fmt   = FMT_U;
                            w_unk   = 1'b0;
                        end
                    end
                    3'b101, 3'b001: begin
                        if (in_inst[15:13] == 3'b101 || XLEN == 32) begin
                            w_imm32 = {{20{in_inst[12]}}, in_inst[12], in_inst[8],
                                       in_inst[10:9], in_inst[6], in_inst[7],
                                       in_inst[2], in_inst[11], in_inst[5:3], 1'b0};
                            w_fmt   = FMT_J;
                            w_unk   = 1'b0;
                        end
                    end
                    3'b110, 3'b111: begin
                        w_imm32 = {{23{in_inst[12]}}, in_inst[12], in_inst[6:5],
                                   in_inst[2], in_inst[11:10], in_inst[4:3], 1'b0};
                        w_fmt   = FMT_B;
                        w_unk   = 1'b0;
                    end
                    default: begin
                        w_unk = 1'b1;
                    end
                endcase
            end
        end
`endif
    end

    assign w_new.imm = XLEN'($signed(w_imm32));
    assign w_new.fmt = w_fmt;
    assign w_new.unk = w_unk;
    assign w_new.tag = in_tag;

    assign w_push = in_valid && !r_skid_v;
    assign w_pop  = r_main_v && out_ready;

    // Main register drives the outputs; skid only fills when main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            if (w_pop) begin
                r_main   <= r_skid;
                r_skid_v <= 1'b0;
            end
        end else if (!r_main_v || w_pop) begin
            r_main_v <= w_push;
            if (w_push) begin
                r_main <= w_new;
            end
        end else if (w_push) begin
            r_skid_v <= 1'b1;
            r_skid   <= w_new;
        end
    end

    assign in_ready  = !r_skid_v;
    assign out_valid = r_main_v;
    assign out_imm   = r_main.imm;
    assign out_fmt   = r_main.fmt;
    assign out_unk   = r_main.unk;
    assign out_tag   = r_main.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// tb_imm_gen_pipe: scoreboard bench driving a 32-bit and a 64-bit (AUIPC pre-shift)
// instance with the same stimulus.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready32, out_valid32, out_unk32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_unk64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [2:0]  f32;
        logic [2:0]  f64;
        logic        u32;
        logic        u64;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUIPC_PRESHIFT(1'b0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_unk(out_unk32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .AUIPC_PRESHIFT(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_unk(out_unk64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] i32, input logic [63:0] i64,
                                input logic [2:0] f, input logic u);
        exp_t e;
        e.i32 = i32; e.i64 = i64;
        e.f32 = f; e.f64 = f;
        e.u32 = u; e.u64 = u;
        e.tag = '0;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        longint s, s64;
        logic [2:0] f;
        logic u;
        logic [11:0] cj;
        logic [8:0] cb;
        s = 0; f = 3'd0; u = 1'b0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: s = $signed(i[31:20]);
            7'h23: begin s = $signed({i[31:25], i[11:7]}); f = 3'd1; end
            7'h63: begin s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); f = 3'd2; end
            7'h37, 7'h17: begin s = $signed({i[31:12], 12'h000}); f = 3'd3; end
            7'h6f: begin s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); f = 3'd4; end
            7'h33: begin s = 0; f = 3'd5; end
            default: begin s = $signed(i[31:20]); u = 1'b1; end
        endcase
        s64 = (i[6:0] == 7'h17) ? (s >>> 1) : s;
        e.f32 = f; e.f64 = f; e.u32 = u; e.u64 = u;
`ifdef IMM_GEN_RVC_EN
        if (i[1:0] != 2'b11) begin
            s = 0; f = 3'd5; u = 1'b1;
            if (i[1:0] == 2'b01) begin
                case (i[15:13])
                    3'd0, 3'd2: begin s = $signed({i[12], i[6:2]}); f = 3'd0; u = 1'b0; end
                    3'd3: if (i[11:7] != 5'd2) begin
                        s = $signed({i[12], i[6:2], 12'h000}); f = 3'd3; u = 1'b0;
                    end
                    3'd1, 3'd5: begin
                        cj[11] = i[12]; cj[4] = i[11]; cj[9:8] = i[10:9];
                        cj[10] = i[8]; cj[6] = i[7]; cj[7] = i[6];
                        cj[3:1] = i[5:3]; cj[5] = i[2]; cj[0] = 1'b0;
                        s = $signed(cj); f = 3'd4; u = 1'b0;
                    end
                    3'd6, 3'd7: begin
                        cb[8] = i[12]; cb[4:3] = i[11:10]; cb[7:6] = i[6:5];
                        cb[2:1] = i[4:3]; cb[5] = i[2]; cb[0] = 1'b0;
                        s = $signed(cb); f = 3'd2; u = 1'b0;
                    end
                    default: ;
                endcase
            end
            s64 = s;
            e.f32 = f; e.f64 = f; e.u32 = u; e.u64 = u;
            if (i[1:0] == 2'b01 && i[15:13] == 3'd1) begin
                s64 = 0; e.f64 = 3'd5; e.u64 = 1'b1;
            end
        end
`endif
        e.i32 = s[31:0];
        e.i64 = s64;
        e.tag = '0;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush) begin
            if (out_valid32 && out_ready) begin
                checks += 2;
                if (q.size() == 0) begin
                    errors += 2;
                    $display("FAIL pop_empty: got tag=%0h, required no output", out_tag32);
                end else begin
                    e = q.pop_front();
                    if ({out_imm32, out_fmt32, out_unk32, out_tag32} !==
                        {e.i32, e.f32, e.u32, e.tag}) begin
                        errors++;
                        $display("FAIL out32: got imm=%h fmt=%0d unk=%0b tag=%0h, required imm=%h fmt=%0d unk=%0b tag=%0h",
                                 out_imm32, out_fmt32, out_unk32, out_tag32, e.i32, e.f32, e.u32, e.tag);
                    end
                    if (!out_valid64 || {out_imm64, out_fmt64, out_unk64, out_tag64} !==
                        {e.i64, e.f64, e.u64, e.tag}) begin
                        errors++;
                        $display("FAIL out64: got v=%0b imm=%h fmt=%0d unk=%0b tag=%0h, required imm=%h fmt=%0d unk=%0b tag=%0h",
                                 out_valid64, out_imm64, out_fmt64, out_unk64, out_tag64, e.i64, e.f64, e.u64, e.tag);
                    end
                end
            end
            if (in_valid && in_ready32) begin
                e = cur;
                e.tag = in_tag;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [7:0] tag, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1; in_inst = inst; in_tag = tag; cur = e;
        @(negedge clk);
        while (!in_ready32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready32) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1 for tag %0h", in_ready32, tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || out_valid32) begin
            errors++;
            $display("FAIL drain: got %0d pending, out_valid=%0b, required 0 and 0", q.size(), out_valid32);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks += 4;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %0b/%0b, required 0", out_valid32, out_valid64);
        end
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %0b/%0b, required 1", in_ready32, in_ready64);
        end
        if (out_imm32 !== 32'h0 || out_imm64 !== 64'h0) begin
            errors++; $display("FAIL rst_imm: got %h/%h, required 0", out_imm32, out_imm64);
        end
        if ({out_fmt32, out_unk32, out_tag32} !== 12'h0) begin
            errors++; $display("FAIL rst_fields: got fmt=%0d unk=%0b tag=%0h, required 0", out_fmt32, out_unk32, out_tag32);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [13];
        exp_t ex [13];
        ins[0]  = 32'hFFF00093; ex[0]  = mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        ins[1]  = 32'hFE112E23; ex[1]  = mk(32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        ins[2]  = 32'hFE000CE3; ex[2]  = mk(32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        ins[3]  = 32'h001000EF; ex[3]  = mk(32'h00000800, 64'h0000000000000800, 3'd4, 1'b0);
        ins[4]  = 32'h123450B7; ex[4]  = mk(32'h12345000, 64'h0000000012345000, 3'd3, 1'b0);
        ins[5]  = 32'h12345097; ex[5]  = mk(32'h12345000, 64'h00000000091A2800, 3'd3, 1'b0);
        ins[6]  = 32'h800000B7; ex[6]  = mk(32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
        ins[7]  = 32'h80000097; ex[7]  = mk(32'h80000000, 64'hFFFFFFFFC0000000, 3'd3, 1'b0);
        ins[8]  = 32'h002081B3; ex[8]  = mk(32'h00000000, 64'h0000000000000000, 3'd5, 1'b0);
        ins[9]  = 32'h0000007F; ex[9]  = mk(32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
        ins[10] = 32'hFFF0007F; ex[10] = mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b1);
        ins[11] = 32'h00812283; ex[11] = mk(32'h00000008, 64'h0000000000000008, 3'd0, 1'b0);
`ifdef IMM_GEN_RVC_EN
        ins[12] = 32'h000010FD; ex[12] = mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
`else
        ins[12] = 32'h000010FD; ex[12] = mk(32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
`endif
        out_ready = 1'b1;
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL lat_idle: got out_valid=%0b, required 0", out_valid32);
        end
        for (int k = 0; k < 13; k++) begin
            send(ins[k], 8'(8'h40 + k), ex[k]);
            if (k == 0) begin
                checks++;
                if (out_valid32 !== 1'b1 || out_tag32 !== 8'h40) begin
                    errors++;
                    $display("FAIL lat_next: got valid=%0b tag=%0h, required 1 and 40", out_valid32, out_tag32);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        exp_t ea;
        int n;
        ea = mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        out_ready = 1'b0;
        send(32'hFFF00093, 8'd1, ea);
        send(32'hFE112E23, 8'd2, mk(32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0));
        in_valid = 1'b1; in_inst = 32'hFE000CE3; in_tag = 8'd3;
        cur = mk(32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            errors++; $display("FAIL bp_full: got in_ready=%0b/%0b, required 0", in_ready32, in_ready64);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid32 !== 1'b1 || out_tag32 !== 8'd1 || out_imm32 !== ea.i32) begin
                errors++;
                $display("FAIL bp_stable: got v=%0b tag=%0h imm=%h, required 1 1 %h", out_valid32, out_tag32, out_imm32, ea.i32);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready32) begin
            errors++; $display("FAIL bp_release: got in_ready=0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'hFFF00093, 8'h11, mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0));
        send(32'h123450B7, 8'h12, mk(32'h12345000, 64'h0000000012345000, 3'd3, 1'b0));
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h001000EF; in_tag = 8'h77;
        cur = mk(32'h00000800, 64'h0000000000000800, 3'd4, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        checks += 2;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %0b/%0b, required 0", out_valid32, out_valid64);
        end
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %0b, required 1", in_ready32);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid32 !== 1'b0) begin
                errors++; $display("FAIL flush_drop: got out_valid=1 tag=%0h, required 0", out_tag32);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'hFFF00093, 8'h21, mk(32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0));
        send(32'hFE112E23, 8'h22, mk(32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0));
        in_valid = 1'b1; in_inst = 32'h000010FD; in_tag = 8'h23;
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got valid=%0b/%0b ready=%0b, required 0/0/1", out_valid32, out_valid64, in_ready32);
        end
        if (out_tag32 !== 8'h0 || out_imm32 !== 32'h0) begin
            errors++; $display("FAIL rst_mid_data: got tag=%0h imm=%h, required 0", out_tag32, out_imm32);
        end
        q.delete();
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h800000B7, 8'h24, mk(32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0));
        drain();
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] inst;
        int r;
        ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h67; ops[3] = 7'h73; ops[4] = 7'h23;
        ops[5] = 7'h63; ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6F; ops[9] = 7'h33;
        for (int k = 0; k < 400; k++) begin
            inst = $urandom;
            r = $urandom_range(0, 5);
            if (r >= 2) inst[6:0] = ops[$urandom_range(0, 9)];
            else if (r == 1) inst[1:0] = 2'b01;
            cur = model(inst);
            in_inst = inst;
            in_tag = 8'(k);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
            if (flush) q.delete();
            flush = 1'b0;
        end
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage of the pipelined RISC-V core.
- Accepts a fetched instruction with a pass-through tag and emits the sign-extended immediate plus a format code one cycle later.
- Generalises the combinational immediate generator:
  - XLEN of 32 or 64.
  - Selectable AUIPC pre-shift mode.
  - Valid/ready flow control through a 2-entry skid buffer, with flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
- TAG_W, 8, width of the opaque tag carried alongside each instruction (e.g. ROB/PC index).
- AUIPC_PRESHIFT, 0, when 1 the AUIPC immediate is output pre-shifted right by one (bits {inst[31:12],11'b0} sign-extended); when 0 it is {inst[31:12],12'b0} sign-extended.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts output.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R/none.
- out_unk  out  1  opcode not recognised (I decode applied).
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Opcode decode on in_inst[6:0]:
  - 0010011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> R: imm=0, fmt=5.
  - Any other opcode -> I decode, fmt=0, out_unk=1.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - U: per AUIPC_PRESHIFT (the setting applies only to opcode 0010111; LUI always uses {inst[31:12],12'b0}).
  - Every immediate is sign-extended from its MSB to XLEN.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Decode happens on the input side; buffer entries store {imm, fmt, unk, tag}.
- Latency: an accepted input appears on out_* the next cycle at the earliest.
- Throughput: 1 per cycle while out_ready=1.
- Buffer: 2 entries, main + skid.
  - in_ready = !skid_full (registered, not combinational from out_ready).
  - Output order is strict FIFO.
  - out_* remain stable while out_valid && !out_ready.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and the new entry replaces the popped one.
- At occupancy 2: in_ready=0, and no input transfer is possible.
- Flush:
  - Occupancy goes to 0 at the next edge.
  - Any input presented in the flush cycle is dropped.
  - out_valid=0 the following cycle.
  - Flush has priority over push and pop.
- Reset values (async, on rst_n=0):
  - out_valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_unk=0, out_tag=0.
  - Occupancy 0.
  - Reset mid-transfer drops all entries.
- X safety: out_imm, out_fmt, out_unk and out_tag hold their last value when out_valid=0; the bench checks them only when valid.

Optional Feature:
- Macro IMM_GEN_RVC_EN.
- When defined:
  - in_inst[1:0]!=2'b11 marks a compressed instruction (low 16 bits used).
  - Supported encodings:
    - c.addi/c.li (quadrant 01, funct3 000/010): imm {i[12],i[6:2]}, fmt I.
    - c.lui (01, 011, rd!=2): {i[12],i[6:2],12'b0}, fmt U.
    - c.j/c.jal (01, 101/001; c.jal only for XLEN=32): CJ offset, fmt J.
    - c.beqz/c.bnez (01, 110/111): CB offset, fmt B.
  - All compressed immediates are sign-extended to XLEN.
  - Other compressed encodings: imm=0, fmt=5, out_unk=1.
- When undefined: compressed words decode as unknown opcodes (I decode, out_unk=1); no RVC logic is present.

Test Plan:
- XLEN=32, out_ready=1:
  - addi 0xFFF00093 -> next cycle out_imm=0xFFFFFFFF, fmt=0.
  - sw 0xFE112E23 -> 0xFFFFFFFC, fmt=1.
  - beq 0xFE000CE3 -> 0xFFFFFFF8, fmt=2.
  - jal 0x001000EF -> 0x00000800, fmt=4.
- U-type:
  - lui 0x123450B7 -> 0x12345000.
  - auipc 0x12345097 -> 0x12345000 with AUIPC_PRESHIFT=0; 0x091A2800 with AUIPC_PRESHIFT=1.
- Backpressure: 3 back-to-back inputs with tags 1,2,3 and out_ready=0 -> tags 1,2 accepted, in_ready=0 on the 3rd; release out_ready -> outputs in order 1,2,3, out_* stable while stalled.
- Flush with occupancy 2 plus an in_valid presented in the same cycle -> next cycle out_valid=0 and in_ready=1; that input never appears.
- XLEN=64: addi 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; opcode 0x0000007F -> out_unk=1.
- IMM_GEN_RVC_EN defined: 0x000010FD (c.addi x1,-1) -> 0xFFFFFFFF, fmt=0; assert rst_n low mid-stream -> out_valid=0 immediately.
